// File: rtl/tcm_bus_arb.sv
// tcm_bus_arb: N-channel request arbiter sharing one TCM cmd/rsp port, routing in-order responses back by ID.
// Build macro TCM_ARB_FIXED_PRIO_EN selects fixed priority (channel 0 highest) instead of round-robin.
module tcm_bus_arb #(
    parameter int NUM_CH     = 2,
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int OSTD_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_cmd_valid,
    output logic [NUM_CH-1:0]          ch_cmd_ready,
    input  logic [NUM_CH-1:0]          ch_cmd_read,
    input  logic [NUM_CH*AW-1:0]       ch_cmd_addr,
    input  logic [NUM_CH*DW-1:0]       ch_cmd_wdata,
    input  logic [NUM_CH*(DW/8)-1:0]   ch_cmd_wmask,
    output logic [NUM_CH-1:0]          ch_rsp_valid,
    input  logic [NUM_CH-1:0]          ch_rsp_ready,
    output logic [DW-1:0]              ch_rsp_rdata,
    output logic                       mem_cmd_valid,
    input  logic                       mem_cmd_ready,
    output logic                       mem_cmd_read,
    output logic [AW-1:0]              mem_cmd_addr,
    output logic [DW-1:0]              mem_cmd_wdata,
    output logic [DW/8-1:0]            mem_cmd_wmask,
    input  logic                       mem_rsp_valid,
    output logic                       mem_rsp_ready,
    input  logic [DW-1:0]              mem_rsp_rdata,
    output logic                       err_unexp_rsp
);
    localparam int MW  = DW / 8;
    localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = $clog2(OSTD_DEPTH);

    logic              any_valid;
    logic [IDW-1:0]    arb_idx;
    logic [IDW-1:0]    grant_idx;
    logic [NUM_CH-1:0] grant;
    logic              lock;
    logic [IDW-1:0]    lock_idx;
    logic              cmd_fire;

    logic [IDW-1:0]    id_mem [OSTD_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [IDW-1:0]    head;

    assign any_valid = |ch_cmd_valid;
    assign full      = (count == (PW+1)'(OSTD_DEPTH));
    assign empty     = (count == '0);

`ifdef TCM_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_cmd_valid[i]) begin
                arb_idx = IDW'(i);
            end
        end
    end
`else
    localparam logic [IDW-1:0] LAST_CH = IDW'(NUM_CH - 1);

    logic [IDW-1:0] rr_ptr;
    logic           rr_found;

    // Two passes: channels at or above the pointer first, then wrap to the ones below it.
    always_comb begin
        rr_found = 1'b0;
        arb_idx  = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rr_found && ch_cmd_valid[i] && (IDW'(i) >= rr_ptr)) begin
                rr_found = 1'b1;
                arb_idx  = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rr_found && ch_cmd_valid[i] && (IDW'(i) < rr_ptr)) begin
                rr_found = 1'b1;
                arb_idx  = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (cmd_fire) begin
            rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // A stalled command keeps its grant so the shared port sees stable cmd fields.
    assign grant_idx     = lock ? lock_idx : arb_idx;
    assign mem_cmd_valid = any_valid & ~full;
    assign cmd_fire      = mem_cmd_valid & mem_cmd_ready;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = any_valid & (grant_idx == IDW'(i));
        end
    end

    assign ch_cmd_ready = grant & {NUM_CH{mem_cmd_ready & ~full}};

    always_comb begin
        mem_cmd_read  = ch_cmd_read[0];
        mem_cmd_addr  = ch_cmd_addr[AW-1:0];
        mem_cmd_wdata = ch_cmd_wdata[DW-1:0];
        mem_cmd_wmask = ch_cmd_wmask[MW-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (grant_idx == IDW'(i)) begin
                mem_cmd_read  = ch_cmd_read[i];
                mem_cmd_addr  = ch_cmd_addr[i*AW +: AW];
                mem_cmd_wdata = ch_cmd_wdata[i*DW +: DW];
                mem_cmd_wmask = ch_cmd_wmask[i*MW +: MW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (cmd_fire) begin
            lock     <= 1'b0;
        end else if (mem_cmd_valid) begin
            lock     <= 1'b1;
            lock_idx <= grant_idx;
        end
    end

    // Outstanding-ID FIFO: one entry per accepted command, popped by its response.
    assign push = cmd_fire;
    assign pop  = mem_rsp_valid & mem_rsp_ready & ~empty;
    assign head = id_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // With nothing outstanding the response is accepted and discarded.
    always_comb begin
        ch_rsp_valid  = '0;
        mem_rsp_ready = empty;
        for (int i = 0; i < NUM_CH; i++) begin
            if (head == IDW'(i)) begin
                ch_rsp_valid[i] = mem_rsp_valid & ~empty;
                if (!empty) begin
                    mem_rsp_ready = ch_rsp_ready[i];
                end
            end
        end
    end

    assign ch_rsp_rdata = mem_rsp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexp_rsp <= 1'b0;
        end else if (mem_rsp_valid && empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcm_bus_arb.sv
// Bench for tcm_bus_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_tcm_bus_arb;
    localparam int NUM_CH = 3;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int OSTD   = 4;
    localparam int MW     = DW / 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_CH-1:0]      ch_cmd_valid;
    logic [NUM_CH-1:0]      ch_cmd_ready;
    logic [NUM_CH-1:0]      ch_cmd_read;
    logic [NUM_CH*AW-1:0]   ch_cmd_addr;
    logic [NUM_CH*DW-1:0]   ch_cmd_wdata;
    logic [NUM_CH*MW-1:0]   ch_cmd_wmask;
    logic [NUM_CH-1:0]      ch_rsp_valid;
    logic [NUM_CH-1:0]      ch_rsp_ready;
    logic [DW-1:0]          ch_rsp_rdata;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic                   mem_cmd_read;
    logic [AW-1:0]          mem_cmd_addr;
    logic [DW-1:0]          mem_cmd_wdata;
    logic [MW-1:0]          mem_cmd_wmask;
    logic                   mem_rsp_valid;
    logic                   mem_rsp_ready;
    logic [DW-1:0]          mem_rsp_rdata;
    logic                   err_unexp_rsp;

    always #5 clk = ~clk;

    tcm_bus_arb #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .OSTD_DEPTH(OSTD)) dut (
        .clk(clk), .rst(rst),
        .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready), .ch_cmd_read(ch_cmd_read),
        .ch_cmd_addr(ch_cmd_addr), .ch_cmd_wdata(ch_cmd_wdata), .ch_cmd_wmask(ch_cmd_wmask),
        .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready), .ch_rsp_rdata(ch_rsp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_read(mem_cmd_read),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
        .err_unexp_rsp(err_unexp_rsp)
    );

    // Pending request per channel, held until accepted.
    bit             p_v    [NUM_CH];
    bit             p_rd   [NUM_CH];
    logic [AW-1:0]  p_addr [NUM_CH];
    logic [DW-1:0]  p_wd   [NUM_CH];
    logic [MW-1:0]  p_wm   [NUM_CH];

    // Reference model: queue of issuing channels, rr pointer, lock, sticky error.
    int  q[$];
    int  m_rr;
    bit  m_lock;
    int  m_lock_idx;
    bit  m_err;

    int  n_chk = 0;
    int  n_err = 0;

    logic [NUM_CH-1:0] o_cready;
    logic [NUM_CH-1:0] o_rvalid;
    logic              o_mcv;
    logic              o_mrr;
    logic              o_err;
    logic [AW-1:0]     o_addr;
    logic [DW-1:0]     o_rdata;
    bit                last_fire;
    int                last_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_cmd_valid[i]          = p_v[i];
            ch_cmd_read[i]           = p_rd[i];
            ch_cmd_addr[i*AW +: AW]  = p_addr[i];
            ch_cmd_wdata[i*DW +: DW] = p_wd[i];
            ch_cmd_wmask[i*MW +: MW] = p_wm[i];
        end
    endtask

    task automatic set_req(input int c, input bit rd, input logic [AW-1:0] a);
        p_v[c]    = 1'b1;
        p_rd[c]   = rd;
        p_addr[c] = a;
        p_wd[c]   = $urandom;
        p_wm[c]   = MW'($urandom);
    endtask

    task automatic model_reset();
        q.delete();
        m_rr       = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        m_err      = 1'b0;
    endtask

    function automatic bit any_pending();
        bit a = 1'b0;
        for (int i = 0; i < NUM_CH; i++) a |= p_v[i];
        return a;
    endfunction

    // One clock: apply inputs, compare outputs with the model, advance the model.
    task automatic step();
        int g;
        int c;
        int head;
        bit exp_mcv;
        bit exp_mrr;
        bit fire;
        logic [NUM_CH-1:0] exp_cr;
        logic [NUM_CH-1:0] exp_rv;
        pack();
        #1;
        if (m_lock) begin
            g = m_lock_idx;
            check("lock_hold", ch_cmd_valid[m_lock_idx], 1);
        end else begin
`ifdef TCM_ARB_FIXED_PRIO_EN
            g = 0;
            for (int k = NUM_CH - 1; k >= 0; k--) if (p_v[k]) g = k;
`else
            g = m_rr;
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                c = (m_rr + k) % NUM_CH;
                if (p_v[c]) g = c;
            end
`endif
        end
        exp_mcv = any_pending() && (q.size() < OSTD);
        exp_cr = '0;
        if (exp_mcv && mem_cmd_ready) exp_cr[g] = 1'b1;
        check("mem_cmd_valid", mem_cmd_valid, exp_mcv);
        check("ch_cmd_ready", ch_cmd_ready, exp_cr);
        if (exp_mcv) begin
            check("mem_cmd_read", mem_cmd_read, p_rd[g]);
            check("mem_cmd_addr", mem_cmd_addr, p_addr[g]);
            check("mem_cmd_wdata", mem_cmd_wdata, p_wd[g]);
            check("mem_cmd_wmask", mem_cmd_wmask, p_wm[g]);
        end
        exp_rv = '0;
        head = -1;
        if (q.size() == 0) begin
            exp_mrr = 1'b1;
        end else begin
            head = q[0];
            if (mem_rsp_valid) exp_rv[head] = 1'b1;
            exp_mrr = ch_rsp_ready[head];
        end
        check("ch_rsp_valid", ch_rsp_valid, exp_rv);
        if (q.size() != 0 || mem_rsp_valid) check("mem_rsp_ready", mem_rsp_ready, exp_mrr);
        check("ch_rsp_rdata", ch_rsp_rdata, mem_rsp_rdata);
        check("err_unexp_rsp", err_unexp_rsp, m_err);
        o_cready = ch_cmd_ready;
        o_rvalid = ch_rsp_valid;
        o_mcv    = mem_cmd_valid;
        o_mrr    = mem_rsp_ready;
        o_err    = err_unexp_rsp;
        o_addr   = mem_cmd_addr;
        o_rdata  = ch_rsp_rdata;
        fire      = exp_mcv && mem_cmd_ready;
        last_fire = fire;
        last_g    = g;
        if (q.size() == 0) begin
            if (mem_rsp_valid) m_err = 1'b1;
        end else if (mem_rsp_valid && ch_rsp_ready[head]) begin
            void'(q.pop_front());
        end
        if (fire) begin
            q.push_back(g);
            m_rr   = (g + 1) % NUM_CH;
            m_lock = 1'b0;
            p_v[g] = 1'b0;
        end else if (exp_mcv) begin
            m_lock     = 1'b1;
            m_lock_idx = g;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        mem_cmd_ready = 1'b1;
        ch_rsp_ready  = '1;
        while ((q.size() != 0 || any_pending()) && n < 50) begin
            mem_rsp_valid = (q.size() != 0);
            mem_rsp_rdata = $urandom;
            step();
            n++;
        end
        check("drain_done", n < 50, 1);
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            p_v[i] = 0; p_rd[i] = 0; p_addr[i] = '0; p_wd[i] = '0; p_wm[i] = '0;
        end
        pack();
        ch_rsp_ready  = '0;
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_cmd_valid", mem_cmd_valid, 0);
        check("rst_ch_cmd_ready", ch_cmd_ready, 0);
        check("rst_ch_rsp_valid", ch_rsp_valid, 0);
        check("rst_err", err_unexp_rsp, 0);
        @(negedge clk);
        rst = 1'b0;

        // Two channels requesting back to back.
        mem_cmd_ready = 1'b1;
        ch_rsp_ready  = '1;
        for (int k = 0; k < 6; k++) begin
            if (!p_v[0]) set_req(0, 1'b1, AW'(16'h0100 + k));
            if (!p_v[1]) set_req(1, 1'b0, AW'(16'h0200 + k));
            mem_rsp_valid = (q.size() != 0);
            mem_rsp_rdata = $urandom;
            step();
            check("t1_fire", last_fire, 1);
`ifdef TCM_ARB_FIXED_PRIO_EN
            check("t1_grant", last_g, 0);
`else
            check("t1_grant", last_g, k % 2);
`endif
        end
        drain();

        // Stalled ch1 command holds grant and address while ch0 arrives.
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        set_req(1, 1'b1, 16'h0040);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) set_req(0, 1'b1, 16'h0080);
            step();
            check("t2_addr_held", o_addr, 16'h0040);
            check("t2_no_ready", o_cready, 0);
        end
        mem_cmd_ready = 1'b1;
        step();
        check("t2_hs_fire", last_fire, 1);
        check("t2_hs_grant", last_g, 1);
        step();
        check("t2_next_fire", last_fire, 1);
        check("t2_next_grant", last_g, 0);
        drain();

        // Outstanding limit.
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, AW'(k * 4));
            step();
            check("t3_issue", last_fire, 1);
        end
        set_req(0, 1'b1, 16'h0010);
        step();
        check("t3_full_valid", o_mcv, 0);
        check("t3_full_ready", o_cready, 0);
        mem_rsp_valid = 1'b1;
        ch_rsp_ready  = '1;
        step();
        check("t3_pop_still_full", o_mcv, 0);
        mem_rsp_valid = 1'b0;
        step();
        check("t3_fifth_fire", last_fire, 1);
        drain();

        // Response routing and back-pressure.
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        set_req(0, 1'b1, 16'h0500); step();
        set_req(1, 1'b1, 16'h0504); step();
        set_req(0, 1'b1, 16'h0508); step();
        mem_rsp_valid = 1'b1;
        ch_rsp_ready  = '1;
        mem_rsp_rdata = 32'hA;
        step();
        check("t4_rv_a", o_rvalid, 3'b001);
        check("t4_rd_a", o_rdata, 32'hA);
        mem_rsp_rdata   = 32'hB;
        ch_rsp_ready[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t4_stall_rv", o_rvalid, 3'b010);
            check("t4_stall_mrr", o_mrr, 0);
        end
        ch_rsp_ready[1] = 1'b1;
        step();
        check("t4_rv_b", o_rvalid, 3'b010);
        check("t4_mrr_b", o_mrr, 1);
        check("t4_rd_b", o_rdata, 32'hB);
        mem_rsp_rdata = 32'hC;
        step();
        check("t4_rv_c", o_rvalid, 3'b001);
        check("t4_rd_c", o_rdata, 32'hC);
        mem_rsp_valid = 1'b0;

        // Unexpected response.
        mem_rsp_valid = 1'b1;
        step();
        check("t5_mrr", o_mrr, 1);
        check("t5_rv", o_rvalid, 0);
        check("t5_err_before", o_err, 0);
        mem_rsp_valid = 1'b0;
        step();
        check("t5_err_set", o_err, 1);
        step();
        check("t5_err_sticky", o_err, 1);

        // Asynchronous reset with commands outstanding and a stalled grant.
        mem_cmd_ready = 1'b1;
        set_req(1, 1'b1, 16'h0600); step();
        set_req(2, 1'b1, 16'h0604); step();
        set_req(0, 1'b1, 16'h0608); step();
        mem_cmd_ready = 1'b0;
        set_req(1, 1'b1, 16'h0077);
        step();
        step();
        #2;
        for (int i = 0; i < NUM_CH; i++) p_v[i] = 1'b0;
        pack();
        rst = 1'b1;
        #1;
        check("t6_err_clr", err_unexp_rsp, 0);
        check("t6_mcv", mem_cmd_valid, 0);
        check("t6_cready", ch_cmd_ready, 0);
        check("t6_rsp_valid", ch_rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_req(0, 1'b1, 16'h0300);
        set_req(1, 1'b1, 16'h0304);
        mem_cmd_ready = 1'b1;
        step();
        check("t6_first_fire", last_fire, 1);
        check("t6_first_grant", last_g, 0);
        drain();

        // Randomized traffic.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!p_v[i] && ($urandom % 10) < 4) set_req(i, 1'($urandom % 2), AW'($urandom));
            end
            mem_cmd_ready = (($urandom % 4) != 0);
            ch_rsp_ready  = NUM_CH'($urandom) | NUM_CH'($urandom);
            if (q.size() != 0) mem_rsp_valid = (($urandom % 10) < 7);
            else               mem_rsp_valid = (($urandom % 50) == 0);
            mem_rsp_rdata = $urandom;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
